port_response_router: RTL and testbench
=======================================

Name: port_response_router

Overview:
Return-path companion to the round-robin port arbiter. The arbiter grants one of PORTCOUNT ports onto a shared in-order resource; this block records the granted port ID for every issued request in a tag FIFO. It then steers each in-order response back to the originating port through a registered one-entry output slot with per-port valid/ACK.

Parameters:
PORTCOUNT, 4, number of client ports
PORTADDRWIDTH, 2, width of a port ID; must equal clog2(PORTCOUNT)
DATABITWIDTH, 16, response data width
DEPTH, 4, maximum outstanding requests; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
clk_en  in  1  clock enable; gates all state updates except resets
sync_rst  in  1  synchronous reset; acts on any rising edge and overrides clk_en
IssueValid  in  1  a request from port IssuePort is being issued to the shared resource this cycle
IssuePort  in  PORTADDRWIDTH  granted port ID (arbiter PortSelection)
IssueReady  out  1  tag FIFO can accept an issue
RespValid  in  1  response from the shared resource is present
RespData  in  DATABITWIDTH  response payload
RespReady  out  1  router accepts the response this cycle
PortRespValid  out  PORTCOUNT  one-hot; bit p means the output slot holds data for port p
PortRespData  out  DATABITWIDTH  output slot data, shared by all ports
PortRespACK  in  PORTCOUNT  port p consumes the slot; only the bit matching the valid port matters
Outstanding  out  clog2(DEPTH)+1  current tag FIFO occupancy
Error  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst async, or sync_rst on an edge):
  - FIFO pointers = 0, Outstanding = 0.
  - PortRespValid = 0, PortRespData = 0, Error = 0.
  - IssueReady = 1, RespReady = 0.
- Tag FIFO: DEPTH entries of PORTADDRWIDTH bits; wrap-around pointers with one extra bit.
  - Full when Outstanding == DEPTH. Empty when Outstanding == 0.
- IssueReady = !full. All readies are combinational from registered state and the same-cycle ACK.
- Issue accept = IssueValid && IssueReady && clk_en.
  - Pushes IssuePort into the FIFO.
  - If IssuePort >= PORTCOUNT: no push, and Error sets.
- Slot free = PortRespValid == 0, or (PortRespACK & PortRespValid) != 0 in the same cycle.
- RespReady = !empty && slot free. No bypass: an issue in the same cycle does not make an empty FIFO non-empty for RespReady.
- Resp accept = RespValid && RespReady && clk_en.
  - Pops the FIFO head.
  - Loads the slot: PortRespValid = onehot(head), PortRespData = RespData.
  - Latency is 1 cycle: response accepted at edge N appears on PortRespValid/PortRespData after edge N.
- ACK without a new load (clk_en high): clears PortRespValid. PortRespData holds its last value.
- ACK and a new load in the same cycle: the load wins, giving back-to-back delivery at one response per cycle.
- ACK on a bit not currently valid: ignored.
- Simultaneous push and pop: Outstanding unchanged. Pop on full and push on the same cycle is impossible because IssueReady is low.
- Spurious response (RespValid && empty && clk_en): not accepted, Error sets.
- Error is sticky; cleared only by rst or sync_rst.
- clk_en low: no push, pop, load, clear, or Error update. Outputs hold.
- Reset mid-operation: all outstanding tags and any undelivered slot data are discarded; no partial state survives.
- Responses are strictly in order; the block never reorders.

Test Plan:
1. Issue ports 2,0,3 on consecutive cycles -> Outstanding 1,2,3. Responses 0xA1,0xB2,0xC3 with ACK held high -> PortRespValid 0100, 0001, 1000 on consecutive cycles with matching data. Outstanding returns to 0.
2. Issue 4 times to port 1 -> IssueReady = 0 at Outstanding = 4. A fifth IssueValid is not pushed. One response and ACK -> IssueReady = 1 next cycle.
3. Slot holds port 1 data with PortRespACK = 0000 and RespValid high for a second response -> RespReady = 0 and data holds. Then PortRespACK = 0010 -> same-cycle accept, new data loaded next cycle.
4. RespValid = 1 with Outstanding = 0 -> RespReady = 0, Error = 1. Error stays 1 after further traffic until sync_rst pulse -> Error = 0.
5. With Outstanding = 3 and slot valid, assert rst asynchronously mid-cycle -> Outstanding = 0 and PortRespValid = 0 immediately, before the next edge. Repeat with sync_rst -> cleared at the next edge even with clk_en = 0.
6. clk_en = 0 while IssueValid and RespValid are high -> no change to Outstanding, slot, or Error. clk_en = 1 -> both accepted in one cycle, Outstanding unchanged.

Source files
------------

// File: rtl/port_response_router.sv
// Return-path router: records the granted port of every issued request in a
// tag FIFO, then steers each in-order response back to that port through a
// registered one-entry output slot with per-port valid/ACK handshake.
module port_response_router #(
  parameter int unsigned PORTCOUNT     = 4,
  parameter int unsigned PORTADDRWIDTH = 2,
  parameter int unsigned DATABITWIDTH  = 16,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      sync_rst,
  input  logic                      IssueValid,
  input  logic [PORTADDRWIDTH-1:0]  IssuePort,
  output logic                      IssueReady,
  input  logic                      RespValid,
  input  logic [DATABITWIDTH-1:0]   RespData,
  output logic                      RespReady,
  output logic [PORTCOUNT-1:0]      PortRespValid,
  output logic [DATABITWIDTH-1:0]   PortRespData,
  input  logic [PORTCOUNT-1:0]      PortRespACK,
  output logic [$clog2(DEPTH):0]    Outstanding,
  output logic                      Error
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW-1:0] FullCnt = PtrW'(DEPTH);
  localparam logic [PORTADDRWIDTH-1:0] MaxPort = PORTADDRWIDTH'(PORTCOUNT - 1);

  // Tag storage and wrap-around pointers (extra MSB distinguishes full/empty)
  logic [PORTADDRWIDTH-1:0] tag_mem_q [DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;

  // Output slot and sticky error
  logic [PORTCOUNT-1:0]     slot_valid_q, slot_valid_d;
  logic [DATABITWIDTH-1:0]  slot_data_q, slot_data_d;
  logic                     error_q, error_d;

  // Derived status
  logic [PtrW-1:0]          count;
  logic                     full;
  logic                     empty;
  logic                     port_ok;
  logic                     slot_acked;
  logic                     slot_free;
  logic                     issue_acc;
  logic                     push;
  logic                     pop;
  logic                     spurious;
  logic [PORTADDRWIDTH-1:0] head_port;
  logic [PORTCOUNT-1:0]     head_onehot;

  // Occupancy, handshake readiness and accept strobes
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    full       = (count == FullCnt);
    empty      = (count == '0);
    port_ok    = (IssuePort <= MaxPort);
    slot_acked = |(PortRespACK & slot_valid_q);
    slot_free  = (slot_valid_q == '0) || slot_acked;
    // Readiness looks only at registered occupancy: no same-cycle issue bypass
    IssueReady = !full;
    RespReady  = !empty && slot_free;
    issue_acc  = IssueValid && !full && clk_en;
    push       = issue_acc && port_ok;
    pop        = RespValid && RespReady && clk_en;
    spurious   = RespValid && empty && clk_en;
  end

  // Decode the FIFO head into the one-hot port select for the slot
  always_comb begin
    head_port   = tag_mem_q[rd_ptr_q[IdxW-1:0]];
    head_onehot = '0;
    for (int p = 0; p < int'(PORTCOUNT); p++) begin
      head_onehot[p] = (head_port == PORTADDRWIDTH'(p));
    end
  end

  // Next-state: pointers, slot load/clear, sticky error; sync_rst overrides all
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    error_d      = error_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    // A new load takes priority over an ACK so back-to-back delivery works
    if (pop) begin
      slot_valid_d = head_onehot;
      slot_data_d  = RespData;
    end else if (clk_en && slot_acked) begin
      slot_valid_d = '0;
    end

    if ((issue_acc && !port_ok) || spurious) begin
      error_d = 1'b1;
    end

    if (sync_rst) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      slot_valid_d = '0;
      slot_data_d  = '0;
      error_d      = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      slot_valid_q <= '0;
      slot_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      error_q      <= error_d;
    end
  end

  // Tag storage write; contents are meaningless once the pointers reset
  always_ff @(posedge clk) begin
    if (push && !sync_rst) begin
      tag_mem_q[wr_ptr_q[IdxW-1:0]] <= IssuePort;
    end
  end

  assign PortRespValid = slot_valid_q;
  assign PortRespData  = slot_data_q;
  assign Outstanding   = count;
  assign Error         = error_q;

endmodule

// File: tb/tb_port_response_router.sv
// Scoreboard bench for port_response_router: stimulus pushes the hand-computed
// expected {one-hot port, data} into a queue; a monitor pops and compares on
// every slot consumption (valid & ACK with clk_en).
module tb_port_response_router;

  localparam int unsigned PC = 4;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          sync_rst = 1'b0;
  logic          iv = 1'b0;
  logic [AW-1:0] ip = '0;
  logic          issue_ready;
  logic          rv = 1'b0;
  logic [DW-1:0] rd = '0;
  logic          resp_ready;
  logic [PC-1:0] p_valid;
  logic [DW-1:0] p_data;
  logic [PC-1:0] ack = '0;
  logic [$clog2(DP):0] outstanding;
  logic          error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PC+DW-1:0] exp_q [$];

  port_response_router #(
    .PORTCOUNT    (PC),
    .PORTADDRWIDTH(AW),
    .DATABITWIDTH (DW),
    .DEPTH        (DP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .sync_rst     (sync_rst),
    .IssueValid   (iv),
    .IssuePort    (ip),
    .IssueReady   (issue_ready),
    .RespValid    (rv),
    .RespData     (rd),
    .RespReady    (resp_ready),
    .PortRespValid(p_valid),
    .PortRespData (p_data),
    .PortRespACK  (ack),
    .Outstanding  (outstanding),
    .Error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [PC-1:0] onehot, input logic [DW-1:0] data);
    exp_q.push_back({onehot, data});
  endtask

  // Monitor: a delivery happens at the edge where the valid port ACKs
  always @(negedge clk) begin
    if (!rst && !sync_rst && clk_en && |(p_valid & ack)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_delivery: got valid=%b data=0x%0h, expected none",
                 p_valid, p_data);
      end else begin
        logic [PC+DW-1:0] e;
        e = exp_q.pop_front();
        check("deliver_valid", 32'(p_valid), 32'(e[PC+DW-1:DW]));
        check("deliver_data", 32'(p_data), 32'(e[DW-1:0]));
      end
    end
  end

  initial begin
    #12 rst = 1'b0;
    step();

    // Reset state
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_issue_ready", 32'(issue_ready), 1);
    check("rst_resp_ready", 32'(resp_ready), 0);
    check("rst_valid", 32'(p_valid), 0);
    check("rst_data", 32'(p_data), 0);
    check("rst_error", 32'(error), 0);

    // 1: issue 2,0,3 then in-order responses with ACK held high
    iv = 1'b1; ip = 2'd2; step(); check("t1_out1", 32'(outstanding), 1);
    ip = 2'd0; step(); check("t1_out2", 32'(outstanding), 2);
    ip = 2'd3; step(); check("t1_out3", 32'(outstanding), 3);
    iv = 1'b0;
    ack = 4'hF;
    rv = 1'b1; rd = 16'h00A1; expect_resp(4'b0100, 16'h00A1); step();
    check("t1_v0", 32'(p_valid), 32'h4);
    rd = 16'h00B2; expect_resp(4'b0001, 16'h00B2); step();
    check("t1_v1", 32'(p_valid), 32'h1);
    rd = 16'h00C3; expect_resp(4'b1000, 16'h00C3); step();
    check("t1_v2", 32'(p_valid), 32'h8);
    rv = 1'b0; step();
    check("t1_out0", 32'(outstanding), 0);
    check("t1_cleared", 32'(p_valid), 0);
    check("t1_data_hold", 32'(p_data), 32'h00C3);

    // 2: fill to DEPTH, fifth issue refused, one response frees a slot
    iv = 1'b1; ip = 2'd1;
    repeat (4) step();
    check("t2_full_out", 32'(outstanding), 4);
    check("t2_full_ready", 32'(issue_ready), 0);
    step();
    check("t2_no_push", 32'(outstanding), 4);
    iv = 1'b0;
    rv = 1'b1; rd = 16'h1111; expect_resp(4'b0010, 16'h1111);
    #1 check("t2_resp_ready", 32'(resp_ready), 1);
    step(); rv = 1'b0;
    check("t2_ready_back", 32'(issue_ready), 1);
    check("t2_out3", 32'(outstanding), 3);
    step();

    // 3: slot held without ACK blocks the next response
    ack = 4'h0;
    rv = 1'b1; rd = 16'h2222; expect_resp(4'b0010, 16'h2222); step();
    rd = 16'h3333;
    check("t3_blocked", 32'(resp_ready), 0);
    step();
    check("t3_hold_data", 32'(p_data), 32'h2222);
    check("t3_hold_valid", 32'(p_valid), 32'h2);
    check("t3_hold_out", 32'(outstanding), 2);
    ack = 4'b0010; expect_resp(4'b0010, 16'h3333);
    #1 check("t3_ack_ready", 32'(resp_ready), 1);
    step(); rv = 1'b0;
    check("t3_new_data", 32'(p_data), 32'h3333);
    check("t3_new_valid", 32'(p_valid), 32'h2);
    step();
    check("t3_out1", 32'(outstanding), 1);
    ack = 4'hF;
    rv = 1'b1; rd = 16'h4444; expect_resp(4'b0010, 16'h4444); step();
    rv = 1'b0; step();
    check("t3_out0", 32'(outstanding), 0);

    // 4: spurious response sets sticky Error; sync_rst clears it
    rv = 1'b1; rd = 16'hDEAD;
    #1 check("t4_not_ready", 32'(resp_ready), 0);
    step(); rv = 1'b0;
    check("t4_error", 32'(error), 1);
    iv = 1'b1; ip = 2'd0; step(); iv = 1'b0;
    rv = 1'b1; rd = 16'h5555; expect_resp(4'b0001, 16'h5555); step();
    rv = 1'b0; step();
    check("t4_sticky", 32'(error), 1);
    sync_rst = 1'b1; step(); sync_rst = 1'b0;
    check("t4_cleared", 32'(error), 0);

    // 5a: asynchronous reset mid-cycle with tags and slot data pending
    ack = 4'h0;
    iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ip = AW'(i); step();
    end
    iv = 1'b0;
    rv = 1'b1; rd = 16'h9999; step(); rv = 1'b0;
    check("t5_pre_out", 32'(outstanding), 3);
    check("t5_pre_valid", 32'(p_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_out", 32'(outstanding), 0);
    check("t5_async_valid", 32'(p_valid), 0);
    check("t5_async_data", 32'(p_data), 0);
    check("t5_async_rready", 32'(resp_ready), 0);
    #3 rst = 1'b0;
    step();

    // 5b: sync_rst acts even with clk_en low
    iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ip = AW'(3 - i); step();
    end
    iv = 1'b0;
    rv = 1'b1; rd = 16'h7A7A; step(); rv = 1'b0;
    check("t5b_pre_valid", 32'(p_valid), 32'h8);
    clk_en = 1'b0; sync_rst = 1'b1; step();
    sync_rst = 1'b0; clk_en = 1'b1;
    check("t5b_out", 32'(outstanding), 0);
    check("t5b_valid", 32'(p_valid), 0);
    check("t5b_data", 32'(p_data), 0);

    // 6: clk_en low freezes everything; then push and pop in one cycle
    iv = 1'b1; ip = 2'd3; step();
    ip = 2'd2; step();
    check("t6_out2", 32'(outstanding), 2);
    clk_en = 1'b0; ip = 2'd0; rv = 1'b1; rd = 16'h6666; ack = 4'hF;
    step(); step();
    check("t6_frozen_out", 32'(outstanding), 2);
    check("t6_frozen_valid", 32'(p_valid), 0);
    check("t6_frozen_err", 32'(error), 0);
    clk_en = 1'b1; expect_resp(4'b1000, 16'h6666); step();
    iv = 1'b0;
    check("t6_pushpop_out", 32'(outstanding), 2);
    check("t6_pushpop_valid", 32'(p_valid), 32'h8);
    rd = 16'h7777; expect_resp(4'b0100, 16'h7777); step();
    rd = 16'h8888; expect_resp(4'b0001, 16'h8888); step();
    rv = 1'b0; step();
    check("t6_drained", 32'(outstanding), 0);
    check("t6_no_err", 32'(error), 0);

    step(); step();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
